// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2, K=3 (7,5) hard-decision Viterbi receiver.
// Holds the code generators, trellis size, FSM state encoding and the branch-output function.
package viterbi_pkg;

    localparam int unsigned K       = 3;
    localparam logic [K-1:0] G0     = 3'b111;
    localparam logic [K-1:0] G1     = 3'b101;
    localparam int unsigned NSTATES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_TRACE,
        ST_DONE
    } rxState_t;

    // Coded pair {c1,c0} emitted when input u leaves state {s1,s0}; c0 is sent first.
    function automatic logic [1:0] expectedPair(input logic [1:0] prevState, input logic u);
        logic [K-1:0] taps;
        taps = {u, prevState};
        return {^(taps & G1), ^(taps & G0)};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Combinational 4-state add-compare-select for one received coded pair.
// Saturating adds; on equal candidates the predecessor with s0=0 survives.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int unsigned MW = 5
)(
    input  logic [NSTATES-1:0][MW-1:0] metricIn,
    input  logic [1:0]                 rxPair,
    output logic [NSTATES-1:0][MW-1:0] metricOut,
    output logic [NSTATES-1:0]         survivor
);

    localparam logic [MW-1:0] MAXM = '1;

    function automatic logic [MW-1:0] satAdd(input logic [MW-1:0] m, input logic [1:0] bm);
        logic [MW:0] sum;
        sum = {1'b0, m} + {{(MW-1){1'b0}}, bm};
        return (sum > {1'b0, MAXM}) ? MAXM : sum[MW-1:0];
    endfunction

    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[0]} + {1'b0, d[1]};
    endfunction

    logic [1:0]    nsBits;
    logic [1:0]    pred0;
    logic [1:0]    pred1;
    logic [MW-1:0] cand0;
    logic [MW-1:0] cand1;

    always_comb begin
        metricOut = '0;
        survivor  = '0;
        nsBits    = '0;
        pred0     = '0;
        pred1     = '0;
        cand0     = '0;
        cand1     = '0;
        // Next state {u,s1}: both predecessors share s1 = ns[0] and differ only in s0.
        for (int unsigned ns = 0; ns < NSTATES; ns++) begin
            nsBits = ns[1:0];
            pred0  = {nsBits[0], 1'b0};
            pred1  = {nsBits[0], 1'b1};
            cand0  = satAdd(metricIn[pred0], hamming(rxPair, expectedPair(pred0, nsBits[1])));
            cand1  = satAdd(metricIn[pred1], hamming(rxPair, expectedPair(pred1, nsBits[1])));
            if (cand0 <= cand1) begin
                metricOut[ns] = cand0;
                survivor[ns]  = 1'b0;
            end else begin
                metricOut[ns] = cand1;
                survivor[ns]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/viterbi_rx_frame.sv
// Serial frame receiver + (7,5) Viterbi decoder with trellis state carried across frames.
// Define VITERBI_ERRCNT_EN to expose err_count (winning path metric of the last frame).
module viterbi_rx_frame
    import viterbi_pkg::*;
#(
    parameter  int unsigned DATA_BITS    = 4,
    parameter  int unsigned CLKS_PER_BIT = 1,
    localparam int unsigned MW           = $clog2(2*DATA_BITS+1)+1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 rx,
    output logic                 ready,
    output logic [DATA_BITS-1:0] outputData
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [MW-1:0]        err_count
`endif
);

    localparam int unsigned NCODED = 2*DATA_BITS;
    localparam int unsigned HALF   = CLKS_PER_BIT/2;
    localparam int unsigned CW     = $clog2(CLKS_PER_BIT+1);
    localparam int unsigned IW     = $clog2(NCODED+1);
    localparam int unsigned SW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [MW-1:0] MAXM = '1;

    rxState_t                   state;
    logic [CW-1:0]              bitClk;
    logic [IW-1:0]              bitIdx;
    logic [SW-1:0]              stepIdx;
    logic                       walking;
    logic                       c0Reg;
    logic [NSTATES-1:0][MW-1:0] metric;
    logic [NSTATES-1:0][MW-1:0] metricNext;
    logic [NSTATES-1:0]         survNext;
    logic [NSTATES-1:0]         surv [DATA_BITS];
    logic [1:0]                 startState;
    logic [1:0]                 traceState;
    logic [1:0]                 endReg;
    logic [1:0]                 endState;
    logic [MW-1:0]              bestMetric;
    logic [DATA_BITS-1:0]       decoded;

    viterbi_acs #(.MW(MW)) acs (
        .metricIn  (metric),
        .rxPair    ({rx, c0Reg}),
        .metricOut (metricNext),
        .survivor  (survNext)
    );

    // Strict < keeps the lowest-index state among equal minima.
    always_comb begin
        endState   = 2'd0;
        bestMetric = metric[0];
        for (int unsigned s = 1; s < NSTATES; s++) begin
            if (metric[s] < bestMetric) begin
                bestMetric = metric[s];
                endState   = 2'(s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bitClk     <= '0;
            bitIdx     <= '0;
            stepIdx    <= '0;
            walking    <= 1'b0;
            c0Reg      <= 1'b0;
            metric     <= '0;
            startState <= '0;
            traceState <= '0;
            endReg     <= '0;
            decoded    <= '0;
            ready      <= 1'b0;
            outputData <= '0;
`ifdef VITERBI_ERRCNT_EN
            err_count  <= '0;
`endif
            for (int unsigned j = 0; j < DATA_BITS; j++) surv[j] <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !rx) begin
                        for (int unsigned s = 0; s < NSTATES; s++)
                            metric[s] <= (2'(s) == startState) ? '0 : MAXM;
                        bitIdx  <= '0;
                        stepIdx <= '0;
                        // With one clock per bit the detecting sample is already the mid-bit confirm.
                        if (CLKS_PER_BIT == 1) begin
                            state  <= ST_DATA;
                            bitClk <= '0;
                        end else begin
                            state  <= ST_START;
                            bitClk <= CW'(1);
                        end
                    end
                end
                ST_START: begin
                    if (bitClk == CW'(HALF) && rx) begin
                        state  <= ST_IDLE;
                        bitClk <= '0;
                    end else if (bitClk == CW'(CLKS_PER_BIT-1)) begin
                        state  <= ST_DATA;
                        bitClk <= '0;
                    end else begin
                        bitClk <= bitClk + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bitClk == CW'(HALF)) begin
                        if (!bitIdx[0]) begin
                            c0Reg <= rx;
                        end else begin
                            metric        <= metricNext;
                            surv[stepIdx] <= survNext;
                            stepIdx       <= stepIdx + 1'b1;
                        end
                    end
                    if (bitClk == CW'(CLKS_PER_BIT-1)) begin
                        bitClk <= '0;
                        if (bitIdx == IW'(NCODED-1)) begin
                            state  <= ST_STOP;
                            bitIdx <= '0;
                        end else begin
                            bitIdx <= bitIdx + 1'b1;
                        end
                    end else begin
                        bitClk <= bitClk + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bitClk == CW'(HALF)) begin
                        state   <= ST_TRACE;
                        bitClk  <= '0;
                        walking <= 1'b0;
                    end else begin
                        bitClk <= bitClk + 1'b1;
                    end
                end
                ST_TRACE: begin
                    if (!walking) begin
                        endReg     <= endState;
                        traceState <= endState;
                        stepIdx    <= SW'(DATA_BITS-1);
                        walking    <= 1'b1;
                    end else begin
                        decoded[stepIdx] <= traceState[1];
                        traceState       <= {traceState[0], surv[stepIdx][traceState]};
                        if (stepIdx == '0) begin
                            state   <= ST_DONE;
                            walking <= 1'b0;
                        end else begin
                            stepIdx <= stepIdx - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    outputData <= decoded;
                    ready      <= 1'b1;
                    startState <= endReg;
`ifdef VITERBI_ERRCNT_EN
                    err_count  <= metric[endReg];
`endif
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_rx_frame.sv
// Directed bench for viterbi_rx_frame: a 4-bit/1-clock instance and an 8-bit/4-clock instance.
// err_count checks are compiled only when VITERBI_ERRCNT_EN is defined.
module tb_viterbi_rx_frame;

    logic       clk;
    logic       rst_n;
    logic       startA, rxA, readyA;
    logic       startB, rxB, readyB;
    logic [3:0] outA;
    logic [7:0] outB;
`ifdef VITERBI_ERRCNT_EN
    logic [4:0] errA;
    logic [5:0] errB;
`endif

    int checks = 0;
    int errors = 0;

    viterbi_rx_frame #(.DATA_BITS(4), .CLKS_PER_BIT(1)) dutA (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (startA),
        .rx         (rxA),
        .ready      (readyA),
        .outputData (outA)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_count  (errA)
`endif
    );

    viterbi_rx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dutB (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (startB),
        .rx         (rxB),
        .ready      (readyB),
        .outputData (outB)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_count  (errB)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setRx(input bit useB, input logic v);
        if (useB) rxB = v;
        else      rxA = v;
    endtask

    // Start bit, nbits coded bits LSB first, stop bit; returns 1ns after the last edge of the stop bit.
    task automatic sendFrame(input bit useB, input logic [63:0] coded, input int nbits, input int cpb);
        @(posedge clk); #1;
        setRx(useB, 1'b0);
        repeat (cpb) @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            setRx(useB, coded[i]);
            repeat (cpb) @(posedge clk);
            #1;
        end
        setRx(useB, 1'b1);
        repeat (cpb) @(posedge clk);
        #1;
    endtask

    task automatic waitReady(input bit useB, input int bound, output int n, output bit got);
        got = 1'b0;
        n   = 0;
        while (!got && n < bound) begin
            @(posedge clk); #1;
            n++;
            got = useB ? readyB : readyA;
        end
    endtask

    task automatic countReady(input bit useB, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (useB ? readyB : readyA) cnt++;
        end
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        rxA   = 1'b1;
        rxB   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (readyA !== 1'b0) begin errors++; $display("FAIL reset_readyA got %b want 0", readyA); end
        checks++; if (outA !== 4'h0) begin errors++; $display("FAIL reset_outA got %h want 0", outA); end
        checks++; if (readyB !== 1'b0) begin errors++; $display("FAIL reset_readyB got %b want 0", readyB); end
        checks++; if (outB !== 8'h00) begin errors++; $display("FAIL reset_outB got %h want 00", outB); end
`ifdef VITERBI_ERRCNT_EN
        checks++; if (errA !== 5'd0) begin errors++; $display("FAIL reset_errA got %0d want 0", errA); end
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_decode_basic();
        int  n;
        bit  got;
        startA = 1'b1;
        sendFrame(1'b0, 64'b00101011, 8, 1);
        waitReady(1'b0, 40, n, got);
        checks++; if (!got) begin errors++; $display("FAIL basic_ready got none want pulse"); end
        checks++; if (n != 6) begin errors++; $display("FAIL basic_latency got %0d want 6", n); end
        checks++; if (outA !== 4'b1011) begin errors++; $display("FAIL basic_data got %b want 1011", outA); end
`ifdef VITERBI_ERRCNT_EN
        checks++; if (errA !== 5'd0) begin errors++; $display("FAIL basic_err got %0d want 0", errA); end
`endif
        @(posedge clk); #1;
        checks++; if (readyA !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", readyA); end
    endtask

    task automatic test_reset_midframe();
        int n;
        bit got;
        int extra;
        @(posedge clk); #1 rxA = 1'b0;
        @(posedge clk); #1 rxA = 1'b1;
        @(posedge clk); #1 rxA = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        rxA   = 1'b1;
        #2;
        checks++; if (outA !== 4'h0) begin errors++; $display("FAIL midrst_out got %b want 0000", outA); end
        checks++; if (readyA !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", readyA); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sendFrame(1'b0, 64'b00101011, 8, 1);
        waitReady(1'b0, 40, n, got);
        checks++; if (!got || outA !== 4'b1011) begin errors++; $display("FAIL midrst_frame got %b (ready %0d) want 1011", outA, got); end
        countReady(1'b0, 20, extra);
        checks++; if (extra != 0) begin errors++; $display("FAIL midrst_single_ready got %0d extra want 0", extra); end
    endtask

    task automatic test_continuity();
        int n;
        bit got;
        sendFrame(1'b0, 64'b00001101, 8, 1);
        waitReady(1'b0, 40, n, got);
        checks++; if (!got) begin errors++; $display("FAIL cont_ready got none want pulse"); end
        checks++; if (outA !== 4'b0000) begin errors++; $display("FAIL cont_data got %b want 0000", outA); end
`ifdef VITERBI_ERRCNT_EN
        checks++; if (errA !== 5'd0) begin errors++; $display("FAIL cont_err got %0d want 0", errA); end
`endif
    endtask

    task automatic test_start_gating();
        int cnt;
        startA = 1'b0;
        sendFrame(1'b0, 64'b00101011, 8, 1);
        countReady(1'b0, 20, cnt);
        checks++; if (cnt != 0) begin errors++; $display("FAIL gate_ready got %0d pulses want 0", cnt); end
        checks++; if (outA !== 4'b0000) begin errors++; $display("FAIL gate_hold got %b want 0000", outA); end
        startA = 1'b1;
    endtask

    task automatic test_glitch();
        int cnt;
        startB = 1'b1;
        @(posedge clk); #1 rxB = 1'b0;
        @(posedge clk); #1 rxB = 1'b1;
        countReady(1'b1, 120, cnt);
        checks++; if (cnt != 0) begin errors++; $display("FAIL glitch_ready got %0d pulses want 0", cnt); end
    endtask

    task automatic test_corrected_error();
        int n;
        bit got;
        applyReset();
        sendFrame(1'b0, 64'b00101001, 8, 1);
        waitReady(1'b0, 40, n, got);
        checks++; if (!got || outA !== 4'b1011) begin errors++; $display("FAIL corr_data got %b (ready %0d) want 1011", outA, got); end
`ifdef VITERBI_ERRCNT_EN
        checks++; if (errA !== 5'd1) begin errors++; $display("FAIL corr_err got %0d want 1", errA); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [1:0]  encS;
        logic [7:0]  info;
        logic [63:0] coded;
        logic        u;
        int          n;
        bit          got;
        encS   = 2'b00;
        startB = 1'b1;
        for (int f = 0; f < 13; f++) begin
            info  = 8'($urandom);
            coded = '0;
            for (int k = 0; k < 8; k++) begin
                u              = info[k];
                coded[2*k]     = u ^ encS[1] ^ encS[0];
                coded[2*k + 1] = u ^ encS[0];
                encS           = {u, encS[1]};
            end
            sendFrame(1'b1, coded, 16, 4);
            waitReady(1'b1, 60, n, got);
            checks++; if (!got || outB !== info) begin errors++; $display("FAIL stream_frame%0d got %h (ready %0d) want %h", f, outB, got, info); end
`ifdef VITERBI_ERRCNT_EN
            checks++; if (errB !== 6'd0) begin errors++; $display("FAIL stream_err%0d got %0d want 0", f, errB); end
`endif
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        rxA    = 1'b1;
        rxB    = 1'b1;
        test_reset();
        test_decode_basic();
        test_reset_midframe();
        test_continuity();
        test_start_gating();
        test_glitch();
        test_corrected_error();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
